// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup with the fetch PC, trained from EX.
// Optional per-entry 2-bit confidence counters are enabled with `define BTB_COUNTER_EN.
module branch_target_buffer #(
    parameter int ENTRIES  = 64,
    parameter int PC_WIDTH = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] pc_if,
    input  logic [PC_WIDTH-1:0] pc_ex,
    input  logic                branch_taken_ex,
    input  logic [PC_WIDTH-1:0] target_addr_ex,
    output logic [PC_WIDTH-1:0] predicted_target,
    output logic                hit
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX - 2;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_mem    [ENTRIES];
    logic [PC_WIDTH-1:0] target_mem [ENTRIES];

    logic [IDX-1:0]   idx_if;
    logic [IDX-1:0]   idx_ex;
    logic [TAG_W-1:0] tag_if;
    logic [TAG_W-1:0] tag_ex;
    logic             if_match;
    logic             ex_match;

    // Instructions are 4-byte aligned, so the two low PC bits never reach the tables.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_if[1:0], pc_ex[1:0]};

    assign idx_if = pc_if[IDX+1:2];
    assign tag_if = pc_if[PC_WIDTH-1:IDX+2];
    assign idx_ex = pc_ex[IDX+1:2];
    assign tag_ex = pc_ex[PC_WIDTH-1:IDX+2];

    // Valid is evaluated first so an uninitialised tag can never leak X into the result.
    assign if_match = valid_q[idx_if] && (tag_mem[idx_if] == tag_if);
    assign ex_match = valid_q[idx_ex] && (tag_mem[idx_ex] == tag_ex);

`ifdef BTB_COUNTER_EN
    logic [1:0] cnt_q [ENTRIES];
    logic [1:0] cnt_ex;

    assign cnt_ex = cnt_q[idx_ex];
    assign hit    = if_match && cnt_q[idx_if][1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= 2'd0;
            end
        end else if (branch_taken_ex) begin
            valid_q[idx_ex] <= 1'b1;
            if (!ex_match) begin
                cnt_q[idx_ex] <= 2'd2;
            end else if (cnt_ex != 2'd3) begin
                cnt_q[idx_ex] <= cnt_ex + 2'd1;
            end
        end else if (ex_match && cnt_ex != 2'd0) begin
            // A not-taken match only weakens confidence; the entry stays allocated.
            cnt_q[idx_ex] <= cnt_ex - 2'd1;
        end
    end
`else
    assign hit = if_match;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (branch_taken_ex) begin
            valid_q[idx_ex] <= 1'b1;
        end else if (ex_match) begin
            valid_q[idx_ex] <= 1'b0;
        end
    end
`endif

    // NOTE: tag/target arrays are deliberately not reset; the valid bits alone guard them.
    always_ff @(posedge clk) begin
        if (reset && branch_taken_ex) begin
            tag_mem[idx_ex]    <= tag_ex;
            target_mem[idx_ex] <= target_addr_ex;
        end
    end

    assign predicted_target = hit ? target_mem[idx_if] : '0;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed steps plus a short randomised phase
// checked against a behavioural model through an expected-result queue.
module tb_branch_target_buffer;

    localparam int PCW = 64;
    localparam logic [PCW-1:0] IDLE_PC = 64'hFFFF_FFFF_FFFF_FFF0;

    logic           clk = 1'b0;
    logic           reset;
    logic [PCW-1:0] pc_if;
    logic [PCW-1:0] pc_ex;
    logic           branch_taken_ex;
    logic [PCW-1:0] target_addr_ex;
    logic [PCW-1:0] predicted_target;
    logic           hit;

    always #5 clk = ~clk;

    branch_target_buffer #(.ENTRIES(64), .PC_WIDTH(PCW)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_if            (pc_if),
        .pc_ex            (pc_ex),
        .branch_taken_ex  (branch_taken_ex),
        .target_addr_ex   (target_addr_ex),
        .predicted_target (predicted_target),
        .hit              (hit)
    );

    typedef struct {
        string          name;
        logic           exp_hit;
        logic [PCW-1:0] exp_tgt;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Behavioural reference: 64 entries, index pc[7:2], tag pc[63:8].
    logic           m_valid [64];
    logic [55:0]    m_tag   [64];
    logic [PCW-1:0] m_tgt   [64];
    logic [1:0]     m_cnt   [64];

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 2'd0;
        end
    endtask

    task automatic model_train(input logic [PCW-1:0] pc, input logic taken, input logic [PCW-1:0] tgt);
        int   i;
        logic match;
        i     = int'(pc[7:2]);
        match = m_valid[i] && (m_tag[i] == pc[63:8]);
`ifdef BTB_COUNTER_EN
        if (taken) begin
            m_cnt[i]   = !match ? 2'd2 : (m_cnt[i] == 2'd3 ? 2'd3 : m_cnt[i] + 2'd1);
            m_valid[i] = 1'b1;
            m_tag[i]   = pc[63:8];
            m_tgt[i]   = tgt;
        end else if (match) begin
            m_cnt[i] = (m_cnt[i] == 2'd0) ? 2'd0 : m_cnt[i] - 2'd1;
        end
`else
        if (taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = pc[63:8];
            m_tgt[i]   = tgt;
        end else if (match) begin
            m_valid[i] = 1'b0;
        end
`endif
    endtask

    task automatic check_lookup(input string name, input logic [PCW-1:0] pc,
                                input logic eh, input logic [PCW-1:0] et);
        exp_t e;
        pc_if = pc;
        sb.push_back('{name, eh, et});
        #1;
        e = sb.pop_front();
        tests_run++;
        assert (hit === e.exp_hit && predicted_target === e.exp_tgt)
        else begin
            tests_failed++;
            $error("FAIL %s: observed hit=%0b target=%h, expected hit=%0b target=%h",
                   e.name, hit, predicted_target, e.exp_hit, e.exp_tgt);
        end
    endtask

    task automatic check_model(input string name, input logic [PCW-1:0] pc);
        int   i;
        logic eh;
        i  = int'(pc[7:2]);
        eh = m_valid[i] && (m_tag[i] == pc[63:8]);
`ifdef BTB_COUNTER_EN
        eh = eh && m_cnt[i][1];
`endif
        check_lookup(name, pc, eh, eh ? m_tgt[i] : '0);
    endtask

    task automatic train(input logic [PCW-1:0] pc, input logic taken, input logic [PCW-1:0] tgt);
        @(negedge clk);
        pc_ex           = pc;
        branch_taken_ex = taken;
        target_addr_ex  = tgt;
        @(posedge clk);
        #1;
        pc_ex           = IDLE_PC;
        branch_taken_ex = 1'b0;
        model_train(pc, taken, tgt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PCW-1:0] rpc;
        logic [PCW-1:0] rtgt;
        logic           rtaken;

        reset           = 1'b0;
        pc_if           = 64'h1000;
        pc_ex           = IDLE_PC;
        branch_taken_ex = 1'b0;
        target_addr_ex  = '0;
        model_clear();

        check_lookup("reset_hold", 64'h1000, 1'b0, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_lookup("post_reset", 64'h1000, 1'b0, 64'h0);

        // First write: not visible during its own cycle, visible after the edge.
        @(negedge clk);
        pc_ex           = 64'h1000;
        branch_taken_ex = 1'b1;
        target_addr_ex  = 64'h2000;
        check_lookup("same_cycle_no_bypass", 64'h1000, 1'b0, 64'h0);
        @(posedge clk);
        #1;
        pc_ex           = IDLE_PC;
        branch_taken_ex = 1'b0;
        model_train(64'h1000, 1'b1, 64'h2000);
        check_lookup("after_write", 64'h1000, 1'b1, 64'h2000);

        // Aliasing: 0x1100 shares index 0 with 0x1000.
        check_lookup("alias_tag_miss", 64'h1100, 1'b0, 64'h0);
        train(64'h1100, 1'b1, 64'h3000);
        check_lookup("alias_hit", 64'h1100, 1'b1, 64'h3000);
        check_lookup("alias_evicted", 64'h1000, 1'b0, 64'h0);
        train(64'h1100, 1'b1, 64'h3000);
        check_lookup("repeat_train", 64'h1100, 1'b1, 64'h3000);

        // Not-taken invalidation (or counter drop below threshold).
        train(64'h1000, 1'b1, 64'h2000);
        check_lookup("retrain_hit", 64'h1000, 1'b1, 64'h2000);
        check_lookup("offset_ignored", 64'h1003, 1'b1, 64'h2000);
        train(64'h1000, 1'b0, 64'h0);
        check_lookup("not_taken_miss", 64'h1000, 1'b0, 64'h0);

        train(64'h2004, 1'b1, 64'h5000);
        check_lookup("idx1_hit", 64'h2004, 1'b1, 64'h5000);
        train(64'h1004, 1'b0, 64'h0);
        check_lookup("nt_nomatch_keeps", 64'h2004, 1'b1, 64'h5000);
        check_lookup("nt_nomatch_pc_miss", 64'h1004, 1'b0, 64'h0);

        // Boundary index and tag MSB.
        train(64'h0000_0000_0000_00FC, 1'b1, 64'hABC0);
        check_lookup("top_index_hit", 64'h0000_0000_0000_00FC, 1'b1, 64'hABC0);
        check_lookup("tag_msb_miss", 64'h8000_0000_0000_00FC, 1'b0, 64'h0);
        train(64'h8000_0000_0000_00FC, 1'b1, 64'hDEAD_BEEF_0000_1234);
        check_lookup("tag_msb_hit", 64'h8000_0000_0000_00FC, 1'b1, 64'hDEAD_BEEF_0000_1234);

        // Asynchronous reset mid-cycle, and an update edge during reset.
        train(64'h3000, 1'b1, 64'h100);
        train(64'h3008, 1'b1, 64'h200);
        check_lookup("pre_reset_hit", 64'h3000, 1'b1, 64'h100);
        @(posedge clk);
        #3;
        reset = 1'b0;
        check_lookup("async_reset_drop", 64'h3000, 1'b0, 64'h0);
        @(negedge clk);
        pc_ex           = 64'h3010;
        branch_taken_ex = 1'b1;
        target_addr_ex  = 64'h400;
        @(posedge clk);
        #1;
        pc_ex           = IDLE_PC;
        branch_taken_ex = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        check_lookup("reset_cleared_3000", 64'h3000, 1'b0, 64'h0);
        check_lookup("reset_cleared_3008", 64'h3008, 1'b0, 64'h0);
        check_lookup("update_in_reset_ignored", 64'h3010, 1'b0, 64'h0);
        check_lookup("reset_cleared_2004", 64'h2004, 1'b0, 64'h0);

`ifdef BTB_COUNTER_EN
        train(64'h1000, 1'b1, 64'h2000);
        train(64'h1000, 1'b1, 64'h2000);
        train(64'h1000, 1'b0, 64'h0);
        check_lookup("cnt_3_to_2_hit", 64'h1000, 1'b1, 64'h2000);
        train(64'h1000, 1'b0, 64'h0);
        check_lookup("cnt_1_miss", 64'h1000, 1'b0, 64'h0);
        train(64'h1000, 1'b0, 64'h0);
        train(64'h1000, 1'b0, 64'h0);
        train(64'h1000, 1'b1, 64'h2400);
        check_lookup("cnt_sat0_then_1_miss", 64'h1000, 1'b0, 64'h0);
        train(64'h1000, 1'b1, 64'h2800);
        check_lookup("cnt_2_refreshed", 64'h1000, 1'b1, 64'h2800);
`endif

        // Randomised training over a small aliasing PC set.
        for (int n = 0; n < 60; n++) begin
            rpc    = {54'($urandom_range(0, 2)), 8'h00, 2'b00} | 64'({$urandom_range(0, 3), 2'b00});
            rpc    = (rpc & ~64'hFF) << 0 | rpc;
            rtaken = 1'($urandom_range(0, 1));
            rtgt   = {$urandom, $urandom};
            train(rpc, rtaken, rtgt);
            rpc = 64'({$urandom_range(0, 2), 8'h00}) | 64'({$urandom_range(0, 3), 2'b00});
            check_model("random_lookup", rpc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
